muldiv_unit: RTL

Iterative RV32M multiply/divide unit that executes all eight M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over multiple cycles. It sits beside the ALU in the execute stage and is sequenced by a four-state FSM. It connects to the pipeline through a valid/ready request port and a valid/ready response port. Pipeline flush and interrupt entry can kill an operation in flight.

---
 rtl/decoder_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 29 ++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared decode constants for the execute stage, plus the multiply/divide FSM state type.
package decoder_pkg;

  localparam logic [2:0] TYPE_MUL    = 3'b000;
  localparam logic [2:0] TYPE_MULH   = 3'b001;
  localparam logic [2:0] TYPE_MULHSU = 3'b010;
  localparam logic [2:0] TYPE_MULHU  = 3'b011;
  localparam logic [2:0] TYPE_DIV    = 3'b100;
  localparam logic [2:0] TYPE_DIVU   = 3'b101;
  localparam logic [2:0] TYPE_REM    = 3'b110;
  localparam logic [2:0] TYPE_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_t;

  function automatic logic md_is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic md_rs1_signed(input logic [2:0] f);
    return (f == TYPE_MULH) || (f == TYPE_MULHSU) || (f == TYPE_DIV) || (f == TYPE_REM);
  endfunction

  function automatic logic md_rs2_signed(input logic [2:0] f);
    return (f == TYPE_MULH) || (f == TYPE_DIV) || (f == TYPE_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the muldiv datapath: shift-add for multiply, subtract-restore for divide.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic                div_i,
  input  logic [2*XLEN-1:0]   acc_i,
  input  logic [XLEN-1:0]     opd_i,
  output logic [2*XLEN-1:0]   acc_o
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] trial;

  always_comb begin
    add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opd_i} : '0);
    // Partial remainder shifted left with the next dividend bit brought in.
    trial   = acc_i[2*XLEN-1:XLEN-1] - {1'b0, opd_i};
    if (div_i) begin
      if (trial[XLEN]) begin
        acc_o = {acc_i[2*XLEN-2:0], 1'b0};
      end else begin
        acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready request and response ports.
module muldiv_unit
  import decoder_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam logic [XLEN-1:0] MinNeg   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [4:0]      LastIter = 5'(XLEN-1);

  muldiv_state_t     state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic [2*XLEN-1:0] step_acc;
  logic              a_neg, b_neg, div_zero, div_ovf, req_div;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .div_i (op_q[2]),
    .acc_i (acc_q),
    .opd_i (opd_q),
    .acc_o (step_acc)
  );

  always_comb begin
    req_div  = md_is_div(funct3_i);
    a_neg    = md_rs1_signed(funct3_i) & rs1_i[XLEN-1];
    b_neg    = md_rs2_signed(funct3_i) & rs2_i[XLEN-1];
    mag_a    = a_neg ? -rs1_i : rs1_i;
    mag_b    = b_neg ? -rs2_i : rs2_i;
    div_zero = req_div && (rs2_i == '0);
    div_ovf  = ((funct3_i == TYPE_DIV) || (funct3_i == TYPE_REM)) &&
               (rs1_i == MinNeg) && (rs2_i == '1);

    prod_fix = neg_q_q ? -acc_q : acc_q;
    quo_fix  = neg_q_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_r_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    opd_d       = opd_q;
    acc_d       = acc_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    result_d    = result_q;
    rsp_valid_d = rsp_valid_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d    = funct3_i;
          cnt_d   = '0;
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          if (div_zero) begin
            // funct3[1] distinguishes REM/REMU from DIV/DIVU.
            result_d    = funct3_i[1] ? rs1_i : '1;
            rsp_valid_d = 1'b1;
            state_d     = DONE;
          end else if (div_ovf) begin
            result_d    = funct3_i[1] ? '0 : MinNeg;
            rsp_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, (req_div ? mag_a : mag_b)};
            opd_d   = req_div ? mag_b : mag_a;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastIter) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (op_q[2]) begin
          result_d = op_q[1] ? rem_fix : quo_fix;
        end else if (op_q == TYPE_MUL) begin
          result_d = prod_fix[XLEN-1:0];
        end else begin
          result_d = prod_fix[2*XLEN-1:XLEN];
        end
        rsp_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over everything, including an accept in IDLE.
    if (flush_i) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
      result_d    = result_q;
      op_d        = op_q;
      opd_d       = opd_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      neg_q_d     = neg_q_q;
      neg_r_d     = neg_r_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      opd_q       <= '0;
      acc_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      result_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      opd_q       <= opd_d;
      acc_q       <= acc_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign result_o    = result_q;
  assign rsp_valid_o = rsp_valid_q;
  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);

endmodule
